// File: rtl/register_mod_nbits_if.sv
// ----------------------------------------------------------------------------
// register_mod_nbits_if
//   Control and status bundle for one modulo time-field register.
//   Ports (all WIDTH-dependent where noted):
//     Enable   qualifies Load/Inc/Dec; 0 = hold
//     Load     synchronous parallel load of D
//     D        load data [WIDTH]
//     Inc      step +1 modulo MODULUS
//     Dec      step -1 modulo MODULUS
//     Q        stored value [WIDTH]
//     Q_n      bitwise complement of Q [WIDTH]
//     Carry    1-cycle pulse on MODULUS-1 -> 0 wrap
//     Borrow   1-cycle pulse on 0 -> MODULUS-1 wrap
//     LoadErr  1-cycle pulse on an out-of-range load
//   master drives the controls, slave (the register) drives the status.
// ----------------------------------------------------------------------------
interface register_mod_nbits_if #(
    parameter int WIDTH = 6
);
    logic             Enable;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Inc;
    logic             Dec;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_n;
    logic             Carry;
    logic             Borrow;
    logic             LoadErr;

    modport master (
        output Enable, Load, D, Inc, Dec,
        input  Q, Q_n, Carry, Borrow, LoadErr
    );

    modport slave (
        input  Enable, Load, D, Inc, Dec,
        output Q, Q_n, Carry, Borrow, LoadErr
    );
endinterface

// File: rtl/register_mod_nbits.sv
// ----------------------------------------------------------------------------
// register_mod_nbits
//   N-bit storage register for one alarm-clock time field. Supports a
//   synchronous parallel load, modulo up/down stepping and registered
//   single-cycle wrap pulses used to chain into the next field.
//   Parameters:
//     WIDTH      register width (1..16)
//     MODULUS    count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//     RESET_VAL  value forced while Clear is low (< MODULUS)
//   Ports:
//     Clock      rising-edge clock
//     Clear      asynchronous active-low reset, dominates all inputs
//     bus        slave side of register_mod_nbits_if (controls in, Q/pulses out)
// ----------------------------------------------------------------------------
module register_mod_nbits #(
    parameter int WIDTH     = 6,
    parameter int MODULUS   = 60,
    parameter int RESET_VAL = 0
) (
    input logic                 Clock,
    input logic                 Clear,
    register_mod_nbits_if.slave bus
);

    // Modulus arithmetic is carried one bit wider so MODULUS == 2**WIDTH
    // is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   MAX_W = MOD_W - ONE_W;
    localparam logic [WIDTH-1:0] MAX_Q = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_p1;
    logic             carry_p1;
    logic             borrow_p1;
    logic             err_p1;

    logic [WIDTH-1:0] q_nxt;
    logic             carry_nxt;
    logic             borrow_nxt;
    logic             err_nxt;

    logic             at_top;
    logic             at_bottom;
    logic             load_ok;

    function automatic logic [WIDTH-1:0] inc_mod(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = {1'b0, v} + ONE_W;
        return (s == MOD_W) ? '0 : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] dec_mod(input logic [WIDTH-1:0] v);
        return (v == '0) ? MAX_Q : (v - ONE_Q);
    endfunction

    assign at_top    = ({1'b0, q_p1} == MAX_W);
    assign at_bottom = (q_p1 == '0);
    assign load_ok   = ({1'b0, bus.D} < MOD_W);

    // Stage p0: next-state decode, Load > single step > hold
    always_comb begin
        q_nxt      = q_p1;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        err_nxt    = 1'b0;
        if (bus.Enable) begin
            if (bus.Load) begin
                // Out-of-range data is rejected so Q never leaves 0..MODULUS-1.
                if (load_ok) begin
                    q_nxt = bus.D;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (bus.Inc && !bus.Dec) begin
                q_nxt     = inc_mod(q_p1);
                carry_nxt = at_top;
            end else if (bus.Dec && !bus.Inc) begin
                q_nxt      = dec_mod(q_p1);
                borrow_nxt = at_bottom;
            end
        end
    end

    // Stage p1: registered value and pulses
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            q_p1      <= RST_Q;
            carry_p1  <= 1'b0;
            borrow_p1 <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            q_p1      <= q_nxt;
            carry_p1  <= carry_nxt;
            borrow_p1 <= borrow_nxt;
            err_p1    <= err_nxt;
        end
    end

    assign bus.Q       = q_p1;
    assign bus.Q_n     = ~q_p1;
    assign bus.Carry   = carry_p1;
    assign bus.Borrow  = borrow_p1;
    assign bus.LoadErr = err_p1;

endmodule

// File: tb/tb_register_mod_nbits.sv
// ----------------------------------------------------------------------------
// tb_register_mod_nbits
//   Directed bench for register_mod_nbits: a seconds field (6-bit, mod 60)
//   chained into a minutes field, plus a separate 2-bit mod-4 instance.
// ----------------------------------------------------------------------------
module tb_register_mod_nbits;

    logic Clock = 1'b0;
    logic Clear = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    register_mod_nbits_if #(.WIDTH(6)) sec_if ();
    register_mod_nbits_if #(.WIDTH(6)) min_if ();
    register_mod_nbits_if #(.WIDTH(2)) w2_if  ();

    register_mod_nbits #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_sec (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (sec_if.slave)
    );

    register_mod_nbits #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_min (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (min_if.slave)
    );

    register_mod_nbits #(.WIDTH(2), .MODULUS(4), .RESET_VAL(0)) u_w2 (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (w2_if.slave)
    );

    // Minutes step on every seconds wrap.
    assign min_if.Inc = sec_if.Carry;

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic sec_ctl(input logic en, input logic ld, input logic [5:0] d,
                           input logic inc, input logic dec);
        sec_if.Enable = en;
        sec_if.Load   = ld;
        sec_if.D      = d;
        sec_if.Inc    = inc;
        sec_if.Dec    = dec;
    endtask

    task automatic w2_ctl(input logic en, input logic ld, input logic [1:0] d,
                          input logic inc, input logic dec);
        w2_if.Enable = en;
        w2_if.Load   = ld;
        w2_if.D      = d;
        w2_if.Inc    = inc;
        w2_if.Dec    = dec;
    endtask

    int carries;

    initial begin
        sec_ctl(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        w2_ctl(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        min_if.Enable = 1'b0;
        min_if.Load   = 1'b0;
        min_if.D      = 6'd0;
        min_if.Dec    = 1'b0;

        // Reset state
        step();
        step();
        check("rst_q",      32'(sec_if.Q),       32'd0);
        check("rst_qn",     32'(sec_if.Q_n),     32'd63);
        check("rst_carry",  32'(sec_if.Carry),   32'd0);
        check("rst_borrow", 32'(sec_if.Borrow),  32'd0);
        check("rst_err",    32'(sec_if.LoadErr), 32'd0);
        Clear = 1'b1;

        // Async clear in the middle of a cycle with Inc pending
        sec_ctl(1'b1, 1'b1, 6'd37, 1'b0, 1'b0);
        step();
        check("ld37_q", 32'(sec_if.Q), 32'd37);
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        #2;
        Clear = 1'b0;
        #1;
        check("aclr_q",     32'(sec_if.Q),     32'd0);
        check("aclr_qn",    32'(sec_if.Q_n),   32'd63);
        check("aclr_carry", 32'(sec_if.Carry), 32'd0);
        step();
        check("aclr_hold_q", 32'(sec_if.Q), 32'd0);
        Clear = 1'b1;
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        check("rel_q",     32'(sec_if.Q),     32'd0);
        check("rel_carry", 32'(sec_if.Carry), 32'd0);

        // Load, then rejected out-of-range load
        sec_ctl(1'b1, 1'b1, 6'd45, 1'b0, 1'b0);
        step();
        check("ld45_q",   32'(sec_if.Q),       32'd45);
        check("ld45_err", 32'(sec_if.LoadErr), 32'd0);
        sec_ctl(1'b1, 1'b1, 6'd60, 1'b0, 1'b0);
        step();
        check("ld60_q",   32'(sec_if.Q),       32'd45);
        check("ld60_err", 32'(sec_if.LoadErr), 32'd1);
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        check("err_once", 32'(sec_if.LoadErr), 32'd0);
        check("err_q",    32'(sec_if.Q),       32'd45);
        sec_ctl(1'b1, 1'b1, 6'd59, 1'b0, 1'b0);
        step();
        check("ld59_q",   32'(sec_if.Q),       32'd59);
        check("ld59_err", 32'(sec_if.LoadErr), 32'd0);

        // Increment across the wrap
        sec_ctl(1'b1, 1'b1, 6'd58, 1'b0, 1'b0);
        step();
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        step();
        check("inc1_q", 32'(sec_if.Q), 32'd59);
        check("inc1_c", 32'(sec_if.Carry), 32'd0);
        step();
        check("inc2_q", 32'(sec_if.Q), 32'd0);
        check("inc2_c", 32'(sec_if.Carry), 32'd1);
        step();
        check("inc3_q", 32'(sec_if.Q), 32'd1);
        check("inc3_c", 32'(sec_if.Carry), 32'd0);

        // Decrement across the wrap
        sec_ctl(1'b1, 1'b1, 6'd1, 1'b0, 1'b0);
        step();
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        step();
        check("dec1_q", 32'(sec_if.Q), 32'd0);
        check("dec1_b", 32'(sec_if.Borrow), 32'd0);
        step();
        check("dec2_q", 32'(sec_if.Q), 32'd59);
        check("dec2_b", 32'(sec_if.Borrow), 32'd1);
        check("dec2_c", 32'(sec_if.Carry), 32'd0);
        step();
        check("dec3_q", 32'(sec_if.Q), 32'd58);
        check("dec3_b", 32'(sec_if.Borrow), 32'd0);

        // Inc+Dec cancel, Enable low holds, Load beats Inc
        sec_ctl(1'b1, 1'b1, 6'd20, 1'b0, 1'b0);
        step();
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
        step();
        check("both_q", 32'(sec_if.Q), 32'd20);
        check("both_c", 32'(sec_if.Carry), 32'd0);
        check("both_b", 32'(sec_if.Borrow), 32'd0);
        sec_ctl(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        step();
        check("dis_q", 32'(sec_if.Q), 32'd20);
        sec_ctl(1'b0, 1'b1, 6'd60, 1'b0, 1'b0);
        step();
        check("dis_err", 32'(sec_if.LoadErr), 32'd0);
        sec_ctl(1'b1, 1'b1, 6'd7, 1'b1, 1'b0);
        step();
        check("ldwin_q", 32'(sec_if.Q), 32'd7);

        // 2-bit modulo-4 instance: full range wraps
        w2_ctl(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        check("w2_ld3", 32'(w2_if.Q), 32'd3);
        w2_ctl(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("w2_wrap_q", 32'(w2_if.Q), 32'd0);
        check("w2_wrap_c", 32'(w2_if.Carry), 32'd1);
        check("w2_qn",     32'(w2_if.Q_n), 32'd3);
        step();
        check("w2_next_q", 32'(w2_if.Q), 32'd1);
        check("w2_next_c", 32'(w2_if.Carry), 32'd0);
        w2_ctl(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        w2_ctl(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step();
        check("w2_dec_q", 32'(w2_if.Q), 32'd3);
        check("w2_dec_b", 32'(w2_if.Borrow), 32'd1);

        // Chain seconds into minutes
        Clear = 1'b0;
        #2;
        Clear = 1'b1;
        min_if.Enable = 1'b1;
        sec_ctl(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        carries = 0;
        for (int i = 1; i <= 121; i++) begin
            step();
            if (sec_if.Carry) carries++;
            if (i == 60)  check("chain60_min",  32'(min_if.Q), 32'd0);
            if (i == 61)  check("chain61_min",  32'(min_if.Q), 32'd1);
            if (i == 120) check("chain120_sec", 32'(sec_if.Q), 32'd0);
            if (i == 120) check("chain120_min", 32'(min_if.Q), 32'd1);
            if (i == 121) check("chain121_min", 32'(min_if.Q), 32'd2);
        end
        check("chain_carries", 32'(carries), 32'd2);
        check("chain_sec_end", 32'(sec_if.Q), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
